// File: rtl/rom_window_scanner.sv
// Address sequencer and reduction engine wrapped around a small synchronous ROM.
// Scans a wrapping address window, folds returned words into sum/max/min/match, and holds the result until acknowledged.
module rom_window_scanner #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [ADDR_W:0]          length,
    input  logic [DATA_W-1:0]        pattern,
    input  logic                     ack,
    output logic [ADDR_W-1:0]        address,
    input  logic [DATA_W-1:0]        data,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W+ADDR_W-1:0] sum,
    output logic [DATA_W-1:0]        max_val,
    output logic [DATA_W-1:0]        min_val,
    output logic [ADDR_W:0]          match_cnt,
    output logic [1:0]               o_state
);

    // Handshake: start is accepted on any edge where it is high in IDLE; ack is
    // accepted on any edge where it is high in DONE. Both are ignored elsewhere.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int                VW     = READ_LATENCY + 1;
    localparam int                SUM_W  = DATA_W + ADDR_W;
    localparam logic [ADDR_W:0]   MAX_N  = (ADDR_W + 1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0]   ONE_N  = (ADDR_W + 1)'(1);
    localparam logic [VW-1:0]     TOP_BIT = VW'(1) << READ_LATENCY;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W:0]     r_n;
    logic [ADDR_W:0]     r_issued;
    logic [DATA_W-1:0]   r_pattern;
    logic [VW-1:0]       r_vld;
    logic [ADDR_W-1:0]   r_address;
    logic [SUM_W-1:0]    r_sum;
    logic [DATA_W-1:0]   r_max;
    logic [DATA_W-1:0]   r_min;
    logic [ADDR_W:0]     r_match;

    logic [ADDR_W:0]     w_len_sat;
    logic                w_load;
    logic                w_issue;
    logic                w_step;
    logic                w_capture;
    logic                w_last_sample;
    logic [VW-1:0]       w_issue_vec;

    assign w_len_sat     = (length > MAX_N) ? MAX_N : length;
    assign w_capture     = r_vld[READ_LATENCY];
    // Last sample: the oldest pipeline slot is valid and nothing younger is in flight.
    assign w_last_sample = w_capture && ((r_vld & ~TOP_BIT) == '0);

    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_issue = 1'b0;
        w_step  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    if (w_len_sat == '0) begin
                        w_next = S_DONE;
                    end else begin
                        w_issue = 1'b1;
                        w_next  = (w_len_sat == ONE_N) ? S_DRAIN : S_READ;
                    end
                end
            end
            S_READ: begin
                w_issue = 1'b1;
                w_step  = 1'b1;
                if (r_issued + ONE_N == r_n) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_sample) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (ack) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_issue_vec    = '0;
        w_issue_vec[0] = w_issue;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n       <= '0;
            r_issued  <= '0;
            r_pattern <= '0;
            r_vld     <= '0;
            r_address <= '0;
            r_sum     <= '0;
            r_max     <= '0;
            r_min     <= '1;
            r_match   <= '0;
        end else begin
            r_vld <= (r_vld << 1) | w_issue_vec;
            if (w_load) begin
                r_n       <= w_len_sat;
                r_pattern <= pattern;
                r_issued  <= ONE_N;
                r_sum     <= '0;
                r_max     <= '0;
                r_min     <= '1;
                r_match   <= '0;
                if (w_issue) begin
                    r_address <= base_addr;
                end
            end else begin
                if (w_step) begin
                    r_address <= r_address + 1'b1;
                    r_issued  <= r_issued + ONE_N;
                end
                if (w_capture) begin
                    r_sum <= r_sum + SUM_W'(data);
                    if (data > r_max) begin
                        r_max <= data;
                    end
                    if (data < r_min) begin
                        r_min <= data;
                    end
                    if (data == r_pattern) begin
                        r_match <= r_match + ONE_N;
                    end
                end
            end
        end
    end

    assign address   = r_address;
    assign busy      = (r_state == S_READ) || (r_state == S_DRAIN);
    assign done      = (r_state == S_DONE);
    assign sum       = r_sum;
    assign max_val   = r_max;
    assign min_val   = r_min;
    assign match_cnt = r_match;
    assign o_state   = r_state;

endmodule

// File: tb/tb_rom_window_scanner.sv
// Runs three scanners (ROM latency 0, 1, 2) in lockstep on shared stimulus, each against its own ROM model,
// and compares every cycle and every final result with a window-level reference computation.
module tb_rom_window_scanner;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] base_addr;
    logic [4:0] length;
    logic [7:0] pattern;
    logic       ack;

    logic [3:0]  address_w [3];
    logic [7:0]  data_w    [3];
    logic        busy_w    [3];
    logic        done_w    [3];
    logic [11:0] sum_w     [3];
    logic [7:0]  max_w     [3];
    logic [7:0]  min_w     [3];
    logic [4:0]  match_w   [3];
    logic [1:0]  state_w   [3];

    int errors = 0;
    int checks = 0;
    int e_n, e_sum, e_max, e_min, e_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_lat
        logic [7:0] rom_comb;
        logic [7:0] rom_q0;
        logic [7:0] rom_q1;
        assign rom_comb = 8'(3 * int'(address_w[g]) + 5);
        always_ff @(posedge clk) begin
            rom_q0 <= rom_comb;
            rom_q1 <= rom_q0;
        end
        if (g == 0) begin : g_l0
            assign data_w[g] = rom_comb;
        end else if (g == 1) begin : g_l1
            assign data_w[g] = rom_q0;
        end else begin : g_l2
            assign data_w[g] = rom_q1;
        end

        rom_window_scanner #(.READ_LATENCY(g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .base_addr (base_addr),
            .length    (length),
            .pattern   (pattern),
            .ack       (ack),
            .address   (address_w[g]),
            .data      (data_w[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g]),
            .sum       (sum_w[g]),
            .max_val   (max_w[g]),
            .min_val   (min_w[g]),
            .match_cnt (match_w[g]),
            .o_state   (state_w[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: reduce the window directly from the ROM contents mem[a] = 3a+5.
    task automatic model(input int base, input int len, input int pat);
        int w;
        e_n   = (len > 16) ? 16 : len;
        e_sum = 0;
        e_max = 0;
        e_min = 255;
        e_cnt = 0;
        for (int k = 0; k < e_n; k++) begin
            w = 3 * ((base + k) % 16) + 5;
            e_sum += w;
            if (w > e_max) e_max = w;
            if (w < e_min) e_min = w;
            if (w == pat) e_cnt++;
        end
    endtask

    task automatic check_results(input string ph);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s L%0d sum", ph, g), 32'(sum_w[g]), 32'(e_sum));
            check($sformatf("%s L%0d max", ph, g), 32'(max_w[g]), 32'(e_max));
            check($sformatf("%s L%0d min", ph, g), 32'(min_w[g]), 32'(e_min));
            check($sformatf("%s L%0d match", ph, g), 32'(match_w[g]), 32'(e_cnt));
        end
    endtask

    task automatic check_reset(input string ph);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s L%0d addr", ph, g), 32'(address_w[g]), 32'd0);
            check($sformatf("%s L%0d busy", ph, g), 32'(busy_w[g]), 32'd0);
            check($sformatf("%s L%0d done", ph, g), 32'(done_w[g]), 32'd0);
            check($sformatf("%s L%0d state", ph, g), 32'(state_w[g]), 32'd0);
            check($sformatf("%s L%0d sum", ph, g), 32'(sum_w[g]), 32'd0);
            check($sformatf("%s L%0d max", ph, g), 32'(max_w[g]), 32'd0);
            check($sformatf("%s L%0d min", ph, g), 32'(min_w[g]), 32'hFF);
            check($sformatf("%s L%0d match", ph, g), 32'(match_w[g]), 32'd0);
        end
    endtask

    // Observation j happens at the falling edge after the j-th rising edge following the start edge.
    task automatic run_scan(input int base, input int len, input int pat, input bit spur);
        int last;
        int lat;
        int exp_addr;
        model(base, len, pat);
        @(negedge clk);
        start     = 1'b1;
        base_addr = 4'(base);
        length    = 5'(len);
        pattern   = 8'(pat);
        @(negedge clk);
        start = 1'b0;
        last  = (e_n == 0) ? 0 : e_n + 2;
        for (int j = 0; j <= last; j++) begin
            for (int g = 0; g < 3; g++) begin
                lat = (e_n == 0) ? 0 : e_n + g;
                check($sformatf("b%0d n%0d j%0d L%0d done", base, e_n, j, g),
                      32'(done_w[g]), 32'(j >= lat));
                check($sformatf("b%0d n%0d j%0d L%0d busy", base, e_n, j, g),
                      32'(busy_w[g]), 32'((e_n > 0) && (j < lat)));
                if (e_n > 0) begin
                    exp_addr = (base + ((j < e_n) ? j : e_n - 1)) % 16;
                    check($sformatf("b%0d n%0d j%0d L%0d addr", base, e_n, j, g),
                          32'(address_w[g]), 32'(exp_addr));
                end
            end
            if (spur && j == 2) begin
                start     = 1'b1;
                base_addr = 4'($urandom_range(0, 15));
                length    = 5'($urandom_range(1, 20));
                pattern   = 8'($urandom_range(0, 255));
            end
            if (spur && j == 3) start = 1'b0;
            @(negedge clk);
        end
        check_results($sformatf("scan b%0d n%0d", base, e_n));
    endtask

    task automatic finish_ack(input int hold, input bit spur);
        for (int c = 0; c < hold; c++) begin
            for (int g = 0; g < 3; g++) begin
                check($sformatf("hold c%0d L%0d done", c, g), 32'(done_w[g]), 32'd1);
                check($sformatf("hold c%0d L%0d busy", c, g), 32'(busy_w[g]), 32'd0);
            end
            check_results($sformatf("hold c%0d", c));
            if (spur && c == 2) begin
                start     = 1'b1;
                base_addr = 4'($urandom_range(0, 15));
                length    = 5'($urandom_range(1, 16));
            end
            if (spur && c == 3) start = 1'b0;
            @(negedge clk);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            for (int g = 0; g < 3; g++) begin
                check($sformatf("post-ack c%0d L%0d done", c, g), 32'(done_w[g]), 32'd0);
                check($sformatf("post-ack c%0d L%0d busy", c, g), 32'(busy_w[g]), 32'd0);
            end
            check_results($sformatf("post-ack c%0d", c));
            @(negedge clk);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = 4'd0;
        length    = 5'd0;
        pattern   = 8'd0;
        ack       = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        // Full sweep with a stray start during READ and during DONE.
        run_scan(0, 16, 20, 1'b1);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("sweep L%0d sum440", g), 32'(sum_w[g]), 32'd440);
            check($sformatf("sweep L%0d max50", g), 32'(max_w[g]), 32'd50);
            check($sformatf("sweep L%0d min5", g), 32'(min_w[g]), 32'd5);
            check($sformatf("sweep L%0d match1", g), 32'(match_w[g]), 32'd1);
        end
        finish_ack(10, 1'b1);

        // Window wrapping through address 15 -> 0.
        run_scan(14, 4, 50, 1'b0);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("wrap L%0d sum110", g), 32'(sum_w[g]), 32'd110);
        end
        finish_ack(1, 1'b0);

        // Empty window, then a saturated length.
        run_scan(5, 0, 0, 1'b0);
        finish_ack(2, 1'b0);
        run_scan(0, 20, 20, 1'b0);
        finish_ack(1, 1'b0);

        // Reset landing at k=6 of a full sweep.
        @(negedge clk);
        start     = 1'b1;
        base_addr = 4'd0;
        length    = 5'd16;
        pattern   = 8'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("mid-scan reset");
        run_scan(3, 2, 14, 1'b0);
        finish_ack(1, 1'b0);

        // Randomized windows.
        for (int r = 0; r < 8; r++) begin
            int b, l, p;
            b = $urandom_range(0, 15);
            l = $urandom_range(0, 20);
            p = ($urandom_range(0, 1) == 1) ? 3 * $urandom_range(0, 15) + 5 : $urandom_range(0, 255);
            run_scan(b, l, p, 1'b0);
            finish_ack($urandom_range(1, 3), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
